// File: rtl/ofs_asp_pkg.sv
// Shared ASP definitions: interrupt line map, IRQ CSR word offsets and IRQ FSM states.
package ofs_asp_pkg;

   localparam int unsigned ASP_MMIO_DATA_WIDTH     = 64;
   localparam int unsigned ASP_NUM_INTERRUPT_LINES = 4;
   localparam int unsigned ASP_NUM_IRQ_USED        = 3;

   localparam int unsigned ASP_IRQ_DMA_0  = 0;
   localparam int unsigned ASP_IRQ_KERNEL = 1;
   localparam int unsigned ASP_IRQ_DMA_1  = 2;

   localparam int unsigned ASP_IRQ_CSR_STATUS = 0;
   localparam int unsigned ASP_IRQ_CSR_ENABLE = 1;
   localparam int unsigned ASP_IRQ_CSR_RAW    = 2;
   localparam int unsigned ASP_IRQ_CSR_COUNT  = 3;

   typedef enum logic [0:0] {IDLE, SEND} t_irq_fsm;

endpackage

// File: rtl/asp_irq_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N-1.
module asp_irq_rr_arb #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      int unsigned j;
      j     = 0;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt aggregator: edge-detect sources into sticky pending bits and send one
// valid/ready message per new pending event; STATUS/ENABLE/RAW/COUNT CSRs on MMIO.
module asp_irq_ctrl import ofs_asp_pkg::*; #(
   parameter int unsigned NUM_LINES      = ASP_NUM_INTERRUPT_LINES,
   parameter int unsigned NUM_USED       = ASP_NUM_IRQ_USED,
   parameter int unsigned CSR_DATA_WIDTH = ASP_MMIO_DATA_WIDTH,
   parameter int unsigned CSR_ADDR_WIDTH = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_LINES-1:0]          irq_in,
   input  logic [CSR_ADDR_WIDTH-1:0]     csr_address,
   input  logic                          csr_read,
   input  logic                          csr_write,
   input  logic [CSR_DATA_WIDTH-1:0]     csr_writedata,
   input  logic [CSR_DATA_WIDTH/8-1:0]   csr_byteenable,
   output logic [CSR_DATA_WIDTH-1:0]     csr_readdata,
   output logic                          csr_readdatavalid,
   output logic                          csr_waitrequest,
   output logic                          intr_valid,
   input  logic                          intr_ready,
   output logic [$clog2(NUM_LINES)-1:0]  intr_vector
);

   localparam int unsigned VEC_W = $clog2(NUM_LINES);
   localparam logic [NUM_LINES-1:0] USED_MASK = NUM_LINES'((64'd1 << NUM_USED) - 64'd1);

   logic [NUM_LINES-1:0]      irq_q, pending_q, pending_d, sent_q, sent_d, enable_q;
   logic [NUM_LINES-1:0]      rise, clr, elig, acc_onehot, arb_grant_unused;
   logic [31:0]               count_q;
   logic [VEC_W-1:0]          rr_ptr_q, arb_idx;
   logic                      arb_found, wr_en, accept;
   logic [CSR_DATA_WIDTH-1:0] rd_data;
   t_irq_fsm                  state_q;
   logic                      unused_bits;

   assign unused_bits = ^{csr_writedata[CSR_DATA_WIDTH-1:NUM_LINES],
                          csr_byteenable[CSR_DATA_WIDTH/8-1:1]};

   assign csr_waitrequest = 1'b0;
   assign wr_en  = csr_write & csr_byteenable[0];
   assign accept = intr_valid & intr_ready;
   assign rise   = irq_in & ~irq_q & enable_q & USED_MASK;
   assign clr    = (wr_en && csr_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_STATUS)) ?
                   csr_writedata[NUM_LINES-1:0] : '0;
   assign elig   = pending_q & ~sent_q & enable_q;

   // A rise on an idle line (or one being cleared) is a new event and re-arms its message;
   // a rise on a still-pending line is coalesced.
   always_comb begin
      acc_onehot = '0;
      if (accept) acc_onehot[intr_vector] = 1'b1;
      pending_d = (pending_q & ~clr) | rise;
      sent_d    = (sent_q | acc_onehot) & ~clr & ~(rise & ~pending_q);
   end

   asp_irq_rr_arb #(
      .N     (NUM_LINES),
      .IDX_W (VEC_W)
   ) u_arb (
      .req   (elig),
      .ptr   (rr_ptr_q),
      .grant (arb_grant_unused),
      .idx   (arb_idx),
      .found (arb_found)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q     <= '0;
         pending_q <= '0;
         sent_q    <= '0;
      end else begin
         irq_q     <= irq_in;
         pending_q <= pending_d;
         sent_q    <= sent_d;
      end
   end

   // Once valid is raised the message always completes, even if its line is disabled/cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         intr_valid  <= 1'b0;
         intr_vector <= '0;
         rr_ptr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_found) begin
                  intr_vector <= arb_idx;
                  intr_valid  <= 1'b1;
                  state_q     <= SEND;
               end
            end
            SEND: begin
               if (intr_ready) begin
                  intr_valid <= 1'b0;
                  rr_ptr_q   <= (32'(intr_vector) == NUM_LINES - 1) ? '0 : intr_vector + 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (csr_address)
         CSR_ADDR_WIDTH'(ASP_IRQ_CSR_STATUS): rd_data[NUM_LINES-1:0] = pending_q;
         CSR_ADDR_WIDTH'(ASP_IRQ_CSR_ENABLE): rd_data[NUM_LINES-1:0] = enable_q;
         CSR_ADDR_WIDTH'(ASP_IRQ_CSR_RAW):    rd_data[NUM_LINES-1:0] = irq_in & USED_MASK;
         CSR_ADDR_WIDTH'(ASP_IRQ_CSR_COUNT):  rd_data[31:0]          = count_q;
         default:                             rd_data                = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q          <= USED_MASK;
         count_q           <= '0;
         csr_readdata      <= '0;
         csr_readdatavalid <= 1'b0;
      end else begin
         csr_readdatavalid <= csr_read;
         if (csr_read) csr_readdata <= rd_data;
         if (wr_en && csr_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_ENABLE)) begin
            enable_q <= csr_writedata[NUM_LINES-1:0] & USED_MASK;
         end
         if (wr_en && csr_address == CSR_ADDR_WIDTH'(ASP_IRQ_CSR_COUNT)) begin
            count_q <= '0;
         end else if (accept) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

endmodule
